systolic_array_ws: RTL and testbench
====================================

// Module: systolic_array_ws
// PURPOSE
// - Parametrised weight-stationary NxN systolic matrix-vector engine; successor to the fixed 8x8 int8 array.
// - Weights load row by row; activation rows then stream at one row/cycle.
// - Computes y[c] = sum_k x[k]*W[k][c] using internal input skew and output deskew.
// - Adds signed/unsigned mode, downstream stall (design_busy) and wide accumulators.
// PARAMETERS
// - N        8   array dimension: rows = columns = activation lanes = output lanes
// - DATA_W   8   weight/activation operand width
// - ACC_W   32   accumulator and output lane width; must be >= 2*DATA_W + clog2(N)
// PORTS
// - clk                input   1           rising-edge clock
// - n_rst              input   1           asynchronous active-low reset
// - load               input   1           write inputs into weight row wr_row
// - inputs             input   N*DATA_W    weight row (load) or activation row (array_start); lane k = bits [k*DATA_W +: DATA_W]
// - array_start        input   1           activation row valid
// - signed_mode        input   1           1 = two's-complement operands, 0 = unsigned
// - design_busy        input   1           downstream stall; freezes the whole datapath
// - array_busy         output  1           at least one activation row in flight
// - activations_valid  output  1           outputs holds a valid result row
// - outputs            output  N*ACC_W     result row; lane c = y[c]
// BEHAVIOUR
// - Reset: weights, skew/PE/deskew registers, wr_row, in-flight count and weights_loaded cleared.
//   - Outputs: outputs = 0, activations_valid = 0, array_busy = 0.
// - Weight load: accepted when load & !array_busy.
//   - W[wr_row] <= inputs; wr_row increments and wraps N-1 -> 0.
//   - weights_loaded sets after the N-th accepted load and stays set; later loads overwrite rows in order.
//   - load while array_busy is ignored; wr_row is unchanged.
// - Activation accept: array_start & weights_loaded & !design_busy & !load.
//   - array_start before weights_loaded is dropped.
//   - load and array_start in the same cycle: load has priority and the row is dropped.
// - Dataflow:
//   - Lane k is skewed by k cycles. Activations move left->right along PE row k; partial sums move top->bottom down column c.
//   - Output column c is deskewed by N-1-c cycles.
// - Latency: exactly 2N cycles from the accept edge to the edge that raises activations_valid (16 for N=8).
// - Throughput: back-to-back accepts give consecutive valid rows in order, with no bubbles.
// - activations_valid is high for exactly 1 unstalled cycle per accepted row; outputs hold their last value otherwise.
// - array_busy: in-flight counter, incremented on accept and decremented on result emission; array_busy = (count != 0).
//   - Simultaneous accept and emit leave the count unchanged.
// - design_busy = 1 stall:
//   - All skew, PE, deskew and valid registers and the counter hold.
//   - outputs and activations_valid hold; no accept occurs.
//   - Latency grows by the stall length; results are unchanged.
// - Arithmetic:
//   - Operands are sign- or zero-extended per mode, and products are extended to ACC_W.
//   - Sums wrap modulo 2^ACC_W; there is no saturation.
// - signed_mode is captured into mode_q on every cycle with array_busy = 0 and is frozen while busy.
//   - Changing it mid-flight has no effect until the array drains.
// - Reset mid-operation: immediate clear to the reset state. In-flight rows and weights are lost.
// STRUCTURE
// - Package sa_pkg:
//   - Default N, DATA_W and ACC_W localparams.
//   - Lane typedefs: data_t = logic [DATA_W-1:0], acc_t = logic [ACC_W-1:0].
//   - Function ext() for mode-dependent extension.
// - Sub-module sa_pe: one processing element.
//   - Holds its weight register.
//   - Registers the activation passed right and the psum_out = psum_in + ext(x)*ext(w) passed down.
//   - Has an enable (stall) input and a weight-write enable.
// - Top level: generate NxN sa_pe instances, skew/deskew shift-register triangles, control counters and the valid pipeline.
// TESTING (N=8, DATA_W=8, ACC_W=32)
// - Reset: assert n_rst=0 for 2 cycles -> outputs=0, activations_valid=0, array_busy=0. array_start before any load -> no valid ever.
// - Load row k all (k+1) (0x01..0x08), then one row of x all 0x01 -> valid exactly 16 cycles later; every lane = 36.
// - Identity weights, 8 back-to-back rows x_j = {j,j+1,..} -> 8 consecutive valid cycles, outputs == x_j in order; array_busy falls the cycle after the last.
// - Weights all 0x02, x all 0xFF:
//   - signed_mode=1 -> every lane = 0xFFFFFFF0 (-16).
//   - signed_mode=0 -> every lane = 4080.
//   - Toggling mode mid-flight leaves the in-flight result unchanged.
// - design_busy high 3 cycles mid-flight -> valid at 19 cycles, values identical.
//   - load asserted while busy -> weights unchanged on the next compute.
//   - load+array_start together -> row dropped, load taken.
// - n_rst pulsed mid-stream -> outputs/valid/busy clear immediately. After reset, array_start without reload -> no valid.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared defaults, lane types and operand extension for the weight-stationary systolic array.
package sa_pkg;

  localparam int SA_N      = 8;
  localparam int SA_DATA_W = 8;
  localparam int SA_ACC_W  = 32;

  // Extension works on a wide container so any DATA_W/ACC_W up to these bounds can share it.
  localparam int OPND_W = 64;
  localparam int EXT_W  = 128;

  typedef logic [SA_DATA_W-1:0] data_t;
  typedef logic [SA_ACC_W-1:0]  acc_t;

  // v must be zero above bit w-1; result is sign- or zero-extended from width w.
  function automatic logic [EXT_W-1:0] ext(input logic [OPND_W-1:0] v,
                                           input int unsigned       w,
                                           input logic              sgn);
    logic [EXT_W-1:0] r;
    r = EXT_W'(v);
    if (sgn && v[w-1]) r = r | (~EXT_W'(0) << w);
    return r;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One weight-stationary processing element: holds a weight, passes the activation right
// and the accumulated partial sum down, both registered and stallable.
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic              w_we,
  input  logic              mode,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] x_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] x_out,
  output logic [ACC_W-1:0]  psum_out
);

  logic [DATA_W-1:0] w_q, w_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic [ACC_W-1:0]  prod;

  function automatic logic [ACC_W-1:0] ext_acc(input logic [DATA_W-1:0] v, input logic sgn);
    return ACC_W'(ext(OPND_W'(v), DATA_W, sgn));
  endfunction

  // Product taken modulo 2^ACC_W, which is exact for both signed and unsigned operands.
  always_comb begin
    prod   = ext_acc(x_in, mode) * ext_acc(w_q, mode);
    w_d    = w_we ? w_in : w_q;
    x_d    = en ? x_in : x_q;
    psum_d = en ? (psum_in + prod) : psum_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      w_q    <= '0;
      x_q    <= '0;
      psum_q <= '0;
    end else begin
      w_q    <= w_d;
      x_q    <= x_d;
      psum_q <= psum_d;
    end
  end

  assign x_out    = x_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/systolic_array_ws.sv
// Weight-stationary NxN systolic matrix-vector engine: y[c] = sum_k x[k]*W[k][c],
// with input skew, output deskew, a 2N-cycle valid pipeline and a global stall.
module systolic_array_ws
  import sa_pkg::*;
#(
  parameter int N      = SA_N,
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load,
  input  logic [N*DATA_W-1:0] inputs,
  input  logic                array_start,
  input  logic                signed_mode,
  input  logic                design_busy,
  output logic                array_busy,
  output logic                activations_valid,
  output logic [N*ACC_W-1:0]  outputs
);

  localparam int LAT   = 2 * N;
  localparam int CNT_W = $clog2(2 * N + 2) + 1;
  localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

  logic en, load_acc, accept, emit;
  logic [N-1:0] w_we;

  logic [ROW_W-1:0]   wr_row_q, wr_row_d;
  logic               weights_loaded_q, weights_loaded_d;
  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LAT-1:0]     vld_q, vld_d;
  logic               activations_valid_q, activations_valid_d;
  logic [N*ACC_W-1:0] outputs_q, outputs_d;

  logic [DATA_W-1:0] xg [N][N+1];
  logic [ACC_W-1:0]  pg [N+1][N];
  logic [ACC_W-1:0]  col_tail [N];

  always_comb begin
    en         = !design_busy;
    array_busy = (cnt_q != '0);
    load_acc   = load && !array_busy;
    accept     = array_start && weights_loaded_q && en && !load;
    emit       = activations_valid_q && en;

    wr_row_d         = wr_row_q;
    weights_loaded_d = weights_loaded_q;
    if (load_acc) begin
      wr_row_d = (wr_row_q == ROW_W'(N - 1)) ? '0 : wr_row_q + ROW_W'(1);
      if (wr_row_q == ROW_W'(N - 1)) weights_loaded_d = 1'b1;
    end
    for (int r = 0; r < N; r++) w_we[r] = load_acc && (wr_row_q == ROW_W'(r));

    // Mode tracks the pin only while idle so an in-flight row is computed consistently.
    mode_d = array_busy ? mode_q : signed_mode;
    cnt_d  = cnt_q + CNT_W'(accept) - CNT_W'(emit);

    vld_d               = vld_q;
    activations_valid_d = activations_valid_q;
    outputs_d           = outputs_q;
    if (en) begin
      vld_d               = {vld_q[LAT-2:0], accept};
      activations_valid_d = vld_q[LAT-1];
      if (vld_q[LAT-1]) begin
        for (int c = 0; c < N; c++) outputs_d[c*ACC_W +: ACC_W] = col_tail[c];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_row_q            <= '0;
      weights_loaded_q    <= 1'b0;
      mode_q              <= 1'b0;
      cnt_q               <= '0;
      vld_q               <= '0;
      activations_valid_q <= 1'b0;
      outputs_q           <= '0;
    end else begin
      wr_row_q            <= wr_row_d;
      weights_loaded_q    <= weights_loaded_d;
      mode_q              <= mode_d;
      cnt_q               <= cnt_d;
      vld_q               <= vld_d;
      activations_valid_q <= activations_valid_d;
      outputs_q           <= outputs_d;
    end
  end

  // Input skew: lane k passes through k+1 registers (capture stage plus k delays).
  for (genvar k = 0; k < N; k++) begin : g_skew
    logic [DATA_W-1:0] sk_q [k+1];
    logic [DATA_W-1:0] sk_d [k+1];

    always_comb begin
      sk_d = sk_q;
      if (en) begin
        sk_d[0] = accept ? inputs[k*DATA_W +: DATA_W] : '0;
        for (int i = 1; i <= k; i++) sk_d[i] = sk_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        for (int i = 0; i <= k; i++) sk_q[i] <= '0;
      end else begin
        sk_q <= sk_d;
      end
    end

    assign xg[k][0] = sk_q[k];
  end

  for (genvar c = 0; c < N; c++) begin : g_top
    assign pg[0][c] = '0;
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .w_we     (w_we[r]),
        .mode     (mode_q),
        .w_in     (inputs[c*DATA_W +: DATA_W]),
        .x_in     (xg[r][c]),
        .psum_in  (pg[r][c]),
        .x_out    (xg[r][c+1]),
        .psum_out (pg[r+1][c])
      );
    end
    logic [DATA_W-1:0] unused_x_tail;
    assign unused_x_tail = xg[r][N];
  end

  // Output deskew: column c is delayed N-1-c cycles so all lanes land together.
  for (genvar c = 0; c < N; c++) begin : g_deskew
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_pass
      assign col_tail[c] = pg[N][c];
    end else begin : g_dly
      logic [ACC_W-1:0] ds_q [D];
      logic [ACC_W-1:0] ds_d [D];

      always_comb begin
        ds_d = ds_q;
        if (en) begin
          ds_d[0] = pg[N][c];
          for (int i = 1; i < D; i++) ds_d[i] = ds_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          for (int i = 0; i < D; i++) ds_q[i] <= '0;
        end else begin
          ds_q <= ds_d;
        end
      end

      assign col_tail[c] = ds_q[D-1];
    end
  end

  assign activations_valid = activations_valid_q;
  assign outputs           = outputs_q;

endmodule

// File: tb/tb_systolic_array_ws.sv
// Directed bench for systolic_array_ws (N=8, DATA_W=8, ACC_W=32): uniform-weight vector
// table plus hand-written sequences for streaming, stall, load arbitration and reset.
module tb_systolic_array_ws;
  import sa_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          load;
  logic [N*DW-1:0] inputs;
  logic          array_start;
  logic          signed_mode;
  logic          design_busy;
  logic          array_busy;
  logic          activations_valid;
  logic [N*AW-1:0] outputs;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  systolic_array_ws #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .load              (load),
    .inputs            (inputs),
    .array_start       (array_start),
    .signed_mode       (signed_mode),
    .design_busy       (design_busy),
    .array_busy        (array_busy),
    .activations_valid (activations_valid),
    .outputs           (outputs)
  );

  typedef struct {
    logic [7:0]  w;
    logic [7:0]  x;
    logic        sm;
    logic [31:0] y;
  } vec_t;

  vec_t tbl [9];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_row(input logic [N*DW-1:0] row);
    inputs = row;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic load_uniform(input data_t v);
    for (int r = 0; r < N; r++) load_row({N{v}});
  endtask

  task automatic load_incr();
    data_t b;
    for (int r = 0; r < N; r++) begin
      b = data_t'(r + 1);
      load_row({N{b}});
    end
  endtask

  task automatic load_identity();
    logic [N*DW-1:0] row;
    for (int r = 0; r < N; r++) begin
      row = '0;
      row[r*DW +: DW] = 8'd1;
      load_row(row);
    end
  endtask

  task automatic issue(input logic [N*DW-1:0] x, input logic sm);
    inputs      = x;
    signed_mode = sm;
    array_start = 1'b1;
    step();
    array_start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (activations_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic chk_lanes(input string name, input logic [31:0] exp);
    for (int c = 0; c < N; c++)
      chk($sformatf("%s lane%0d", name, c), 64'(outputs[c*AW +: AW]), 64'(exp));
  endtask

  task automatic no_valid(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (activations_valid) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat;
    int n;
    logic [N*DW-1:0] row;

    tbl[0] = '{w: 8'h02, x: 8'hFF, sm: 1'b1, y: 32'hFFFF_FFF0};
    tbl[1] = '{w: 8'h02, x: 8'hFF, sm: 1'b0, y: 32'd4080};
    tbl[2] = '{w: 8'hFF, x: 8'hFF, sm: 1'b1, y: 32'd8};
    tbl[3] = '{w: 8'hFF, x: 8'hFF, sm: 1'b0, y: 32'd520200};
    tbl[4] = '{w: 8'h7F, x: 8'h7F, sm: 1'b1, y: 32'd129032};
    tbl[5] = '{w: 8'h80, x: 8'h80, sm: 1'b1, y: 32'd131072};
    tbl[6] = '{w: 8'h80, x: 8'h80, sm: 1'b0, y: 32'd131072};
    tbl[7] = '{w: 8'h80, x: 8'h7F, sm: 1'b1, y: 32'hFFFE_0400};
    tbl[8] = '{w: 8'h80, x: 8'h7F, sm: 1'b0, y: 32'd130048};

    n_rst = 1'b0; load = 1'b0; array_start = 1'b0;
    signed_mode = 1'b0; design_busy = 1'b0; inputs = '0;
    step();
    step();
    chk("reset outputs", 64'(outputs), 64'd0);
    chk("reset valid", 64'(activations_valid), 64'd0);
    chk("reset busy", 64'(array_busy), 64'd0);
    n_rst = 1'b1;
    step();

    issue({N{8'h01}}, 1'b0);
    no_valid("start before load", 40);
    chk("start before load busy", 64'(array_busy), 64'd0);

    load_incr();
    issue({N{8'h01}}, 1'b0);
    wait_valid(lat);
    chk("ramp latency", 64'(lat), 64'd16);
    chk_lanes("ramp", 32'd36);
    step();

    for (int i = 0; i < 9; i++) begin
      load_uniform(tbl[i].w);
      issue({N{tbl[i].x}}, tbl[i].sm);
      wait_valid(lat);
      chk($sformatf("tbl%0d latency", i), 64'(lat), 64'd16);
      chk_lanes($sformatf("tbl%0d", i), tbl[i].y);
      step();
    end

    // Identity weights with eight back-to-back rows.
    load_identity();
    for (int j = 1; j <= N; j++) begin
      for (int k = 0; k < N; k++) row[k*DW +: DW] = 8'(j + k);
      inputs      = row;
      signed_mode = 1'b1;
      array_start = 1'b1;
      step();
    end
    array_start = 1'b0;
    wait_valid(lat);
    chk("stream first latency", 64'(lat), 64'd9);
    for (int j = 1; j <= N; j++) begin
      if (j > 1) step();
      chk($sformatf("stream valid%0d", j), 64'(activations_valid), 64'd1);
      for (int k = 0; k < N; k++)
        chk($sformatf("stream row%0d lane%0d", j, k), 64'(outputs[k*AW +: AW]), 64'(j + k));
      if (j == N) chk("stream busy on last", 64'(array_busy), 64'd1);
    end
    step();
    chk("stream valid after", 64'(activations_valid), 64'd0);
    chk("stream busy after", 64'(array_busy), 64'd0);

    // Mode changes while in flight must not alter the result.
    load_uniform(8'h02);
    issue({N{8'hFF}}, 1'b1);
    for (int i = 0; i < 5; i++) step();
    signed_mode = 1'b0;
    wait_valid(lat);
    chk("mode s->u latency", 64'(lat + 5), 64'd16);
    chk_lanes("mode s->u", 32'hFFFF_FFF0);
    step();
    issue({N{8'hFF}}, 1'b0);
    for (int i = 0; i < 5; i++) step();
    signed_mode = 1'b1;
    wait_valid(lat);
    chk("mode u->s latency", 64'(lat + 5), 64'd16);
    chk_lanes("mode u->s", 32'd4080);
    step();

    // Stall for three cycles, with an ignored load while the array is busy.
    load_incr();
    issue({N{8'h01}}, 1'b0);
    n = 0;
    step(); n++;
    inputs = {N{8'h55}};
    load   = 1'b1;
    step(); n++;
    load   = 1'b0;
    step(); n++;
    step(); n++;
    design_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); n++;
      chk($sformatf("stall no valid%0d", i), 64'(activations_valid), 64'd0);
    end
    design_busy = 1'b0;
    wait_valid(lat);
    chk("stall latency", 64'(n + lat), 64'd19);
    chk_lanes("stall", 32'd36);
    step();
    issue({N{8'h01}}, 1'b0);
    wait_valid(lat);
    chk("after busy load latency", 64'(lat), 64'd16);
    chk_lanes("after busy load", 32'd36);
    step();

    // load and array_start together: row dropped, load into row 0 taken.
    inputs      = '0;
    signed_mode = 1'b0;
    load        = 1'b1;
    array_start = 1'b1;
    step();
    load        = 1'b0;
    array_start = 1'b0;
    no_valid("load+start dropped", 40);
    issue({N{8'h01}}, 1'b0);
    wait_valid(lat);
    chk("load+start latency", 64'(lat), 64'd16);
    chk_lanes("load+start", 32'd35);
    step();

    // Asynchronous reset in the middle of a stream.
    issue({N{8'h01}}, 1'b0);
    issue({N{8'h01}}, 1'b0);
    wait_valid(lat);
    chk("pre-reset latency", 64'(lat), 64'd15);
    chk("pre-reset busy", 64'(array_busy), 64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid reset outputs", 64'(outputs), 64'd0);
    chk("mid reset valid", 64'(activations_valid), 64'd0);
    chk("mid reset busy", 64'(array_busy), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    issue({N{8'h01}}, 1'b0);
    no_valid("start after reset", 40);
    chk("after reset busy", 64'(array_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
